// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-add multiplier that stalls the pipeline while a multiply runs in EX
module mul_seq_ctrl #(
    parameter int         WIDTH    = 32,
    parameter logic [2:0] MUL_CODE = 3'b101
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [2:0]       ex_alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             mul_done,
    output logic [WIDTH-1:0] mul_result
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
    logic [WIDTH-1:0] acc_sum;
    logic [CW-1:0]    count_q, count_d;
    logic             start;

    assign start      = state_q == IDLE && ex_valid && ex_alu_ctrl == MUL_CODE && !flush;
    assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign stall      = rst_n && (start || state_q == RUN) && !flush;
    assign mul_done   = state_q == DONE;
    assign mul_result = result_q;

    // Next-state: capture operands on start, one shift-add step per RUN cycle, flush aborts RUN
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = RUN;
                acc_d    = '0;
                mcand_d  = op_a;
                mplier_d = op_b;
                count_d  = '0;
            end
            RUN: if (flush) begin
                state_d = IDLE;
            end else begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = acc_sum;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: vector table, directed corner sequences and a randomized model check
module tb_mul_seq_ctrl;
    localparam int         W   = 32;
    localparam logic [2:0] MUL = 3'b101;

    logic         clk = 1'b0;
    logic         rst_n, ex_valid, flush, stall, mul_done;
    logic [2:0]   ex_alu_ctrl;
    logic [W-1:0] op_a, op_b, mul_result;
    int           n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
    } vec_t;
    vec_t tbl[8];

    mul_seq_ctrl #(.WIDTH(W), .MUL_CODE(MUL)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
        .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall),
        .mul_done(mul_done), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic [W-1:0] res);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_stall", stall, 0);
            chk("idle_done", mul_done, 0);
            chk("idle_result", mul_result, res);
            tick();
        end
    endtask

    // Issue one multiply held in EX through DONE; operands are scrambled while it runs
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p,
                           input bit fl_done);
        ex_valid = 1; ex_alu_ctrl = MUL; op_a = a; op_b = b; flush = 0;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            chk("busy_stall", stall, 1);
            chk("busy_done", mul_done, 0);
            tick();
            op_a = $urandom; op_b = $urandom;
        end
        flush = fl_done;
        @(negedge clk);
        chk("done_pulse", mul_done, 1);
        chk("done_stall", stall, 0);
        chk("done_result", mul_result, p);
        tick();
        flush = 0;
    endtask

    initial begin
        int           rem;
        bit           in_done, st;
        logic [W-1:0] pend, res;

        tbl[0] = '{32'd6, 32'd7, 32'd42};
        tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        tbl[2] = '{32'h80000000, 32'd2, 32'h00000000};
        tbl[3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
        tbl[4] = '{32'h00010000, 32'h00010000, 32'h00000000};
        tbl[5] = '{32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE};
        tbl[6] = '{32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD};
        tbl[7] = '{32'd0, 32'd9, 32'd0};

        rst_n = 0; ex_valid = 1; ex_alu_ctrl = MUL; op_a = 5; op_b = 5; flush = 0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_done", mul_done, 0);
        chk("rst_result", mul_result, 0);
        tick(); tick();
        rst_n = 1; ex_valid = 0;
        idle_cycles(2, 0);

        foreach (tbl[k]) begin
            run_mul(tbl[k].a, tbl[k].b, tbl[k].p, 0);
            ex_valid = 0;
            idle_cycles(1, tbl[k].p);
        end

        run_mul(32'd6, 32'd7, 32'd42, 1);
        ex_valid = 1; ex_alu_ctrl = MUL; op_a = 3; op_b = 5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_busy", stall, 1);
            tick();
        end
        flush = 1;
        @(negedge clk);
        chk("abort_stall", stall, 0);
        chk("abort_done", mul_done, 0);
        tick();
        flush = 0; ex_valid = 0;
        idle_cycles(40, 32'd42);

        ex_valid = 1; flush = 1;
        idle_cycles(5, 32'd42);
        flush = 0;

        run_mul(32'd3, 32'd4, 32'd12, 0);
        run_mul(32'd5, 32'd6, 32'd30, 0);
        ex_valid = 0;
        idle_cycles(1, 32'd30);

        ex_valid = 1; ex_alu_ctrl = MUL; op_a = 9; op_b = 9;
        for (int i = 0; i < 20; i++) tick();
        rst_n = 0;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_done", mul_done, 0);
        chk("midrst_result", mul_result, 0);
        idle_cycles(3, 0);
        rst_n = 1;
        run_mul(32'd2, 32'd2, 32'd4, 0);

        ex_valid = 1; ex_alu_ctrl = 3'b010;
        idle_cycles(50, 32'd4);
        ex_valid = 0; ex_alu_ctrl = MUL;
        idle_cycles(50, 32'd4);

        rst_n = 0;
        tick();
        rst_n = 1;
        rem = 0; in_done = 0; res = 0; pend = 0;
        for (int c = 0; c < 3000; c++) begin
            ex_valid    = $urandom_range(0, 3) != 0;
            ex_alu_ctrl = $urandom_range(0, 1) != 0 ? MUL : 3'($urandom_range(0, 7));
            flush       = $urandom_range(0, 39) == 0;
            op_a        = $urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(0, 255));
            op_b        = $urandom;
            st = rem == 0 && !in_done && ex_valid && ex_alu_ctrl == MUL && !flush;
            @(negedge clk);
            chk("rnd_stall", stall, (st || rem > 0) && !flush);
            chk("rnd_done", mul_done, in_done);
            chk("rnd_result", mul_result, res);
            if (in_done) in_done = 0;
            else if (rem > 0) begin
                if (flush) rem = 0;
                else begin
                    rem--;
                    if (rem == 0) begin
                        in_done = 1;
                        res = pend;
                    end
                end
            end else if (st) begin
                rem  = W;
                pend = op_a * op_b;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
